axis_wr_arbiter: RTL and testbench

- Two-source, packet-atomic, round-robin arbiter. Merges two AXI-Stream write streams into one AXI-Stream master that feeds the memory controller's write slave port.
- Holds a grant from the first beat of a packet through its tlast beat. Tags every output beat with the source index.
- Keeps a saturating per-source count of forwarded packets for status/debug.

---
 rtl/axis_wr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_axis_wr_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_wr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_wr_arbiter
//
// Two-source, packet-atomic, round-robin AXI-Stream arbiter. Merges the s00 and
// s01 write streams into the single m00 stream that feeds the memory
// controller's write slave port. A grant is taken in IDLE and held from the
// first beat of a packet through its tlast beat. Every output beat carries the
// index of its source on m00_axis_tid. A saturating per-source counter records
// how many packets have been forwarded.
//
// Ports
//   axis_aclk        in   clock for all logic
//   axis_areset      in   synchronous, active-high reset
//   s0n_axis_tdata   in   source n data               [DATA_WIDTH]
//   s0n_axis_tstrb   in   source n byte strobes       [DATA_WIDTH/8]
//   s0n_axis_tvalid  in   source n beat valid
//   s0n_axis_tlast   in   source n last beat of packet
//   s0n_axis_tready  out  source n ready (mirrors m00_axis_tready while granted)
//   m00_axis_tdata   out  merged data                 [DATA_WIDTH]
//   m00_axis_tstrb   out  merged strobes              [DATA_WIDTH/8]
//   m00_axis_tvalid  out  merged valid
//   m00_axis_tlast   out  merged last
//   m00_axis_tid     out  index of the granted source
//   m00_axis_tready  in   downstream ready
//   s0n_pkt_count    out  packets completed from source n [CNT_WIDTH]
//   busy             out  high while a grant is held
// -----------------------------------------------------------------------------
module axis_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    axis_aclk,
    input  logic                    axis_areset,

    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                    s00_axis_tvalid,
    input  logic                    s00_axis_tlast,
    output logic                    s00_axis_tready,

    input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
    input  logic                    s01_axis_tvalid,
    input  logic                    s01_axis_tlast,
    output logic                    s01_axis_tready,

    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tvalid,
    output logic                    m00_axis_tlast,
    output logic                    m00_axis_tid,
    input  logic                    m00_axis_tready,

    output logic [CNT_WIDTH-1:0]    s00_pkt_count,
    output logic [CNT_WIDTH-1:0]    s01_pkt_count,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_grant_q;   // source that most recently finished a packet
    logic   pkt_done0;      // tlast beat of source 0 transfers this cycle
    logic   pkt_done1;      // tlast beat of source 1 transfers this cycle

    // Round-robin choice: a lone valid source wins; on a tie the source that
    // did not finish last wins; with nothing valid the arbiter idles.
    function automatic state_t arbitrate(input logic v0, input logic v1,
                                         input logic last_grant);
        if (v0 && v1)
            return last_grant ? GRANT0 : GRANT1;
        else if (v0)
            return GRANT0;
        else if (v1)
            return GRANT1;
        else
            return IDLE;
    endfunction

    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_d         = state_q;
        m00_axis_tdata  = '0;
        m00_axis_tstrb  = '0;
        m00_axis_tvalid = 1'b0;
        m00_axis_tlast  = 1'b0;
        m00_axis_tid    = 1'b0;
        s00_axis_tready = 1'b0;
        s01_axis_tready = 1'b0;
        pkt_done0       = 1'b0;
        pkt_done1       = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = arbitrate(s00_axis_tvalid, s01_axis_tvalid, last_grant_q);
            end

            GRANT0: begin
                m00_axis_tdata  = s00_axis_tdata;
                m00_axis_tstrb  = s00_axis_tstrb;
                m00_axis_tvalid = s00_axis_tvalid;
                m00_axis_tlast  = s00_axis_tlast;
                m00_axis_tid    = 1'b0;
                s00_axis_tready = m00_axis_tready;
                pkt_done0       = s00_axis_tvalid && m00_axis_tready && s00_axis_tlast;
                // The finishing source's tvalid belongs to the beat being
                // consumed, so it does not count as a request for the next
                // packet; the other source is preferred for a bubble-free
                // handoff.
                if (pkt_done0)
                    state_d = arbitrate(1'b0, s01_axis_tvalid, 1'b0);
            end

            GRANT1: begin
                m00_axis_tdata  = s01_axis_tdata;
                m00_axis_tstrb  = s01_axis_tstrb;
                m00_axis_tvalid = s01_axis_tvalid;
                m00_axis_tlast  = s01_axis_tlast;
                m00_axis_tid    = 1'b1;
                s01_axis_tready = m00_axis_tready;
                pkt_done1       = s01_axis_tvalid && m00_axis_tready && s01_axis_tlast;
                if (pkt_done1)
                    state_d = arbitrate(s00_axis_tvalid, 1'b0, 1'b1);
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;   // source 0 wins the first tie
            s00_pkt_count <= '0;
            s01_pkt_count <= '0;
        end else begin
            state_q <= state_d;
            if (pkt_done0) begin
                last_grant_q <= 1'b0;
                if (s00_pkt_count != '1)
                    s00_pkt_count <= s00_pkt_count + 1'b1;
            end
            if (pkt_done1) begin
                last_grant_q <= 1'b1;
                if (s01_pkt_count != '1)
                    s01_pkt_count <= s01_pkt_count + 1'b1;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_axis_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_wr_arbiter
//
// Scoreboard bench for axis_wr_arbiter. A driver process presents beats taken
// from per-source packet queues and pushes each presented beat onto that
// source's expected queue. A monitor process keeps an ownership-level model of
// the arbiter (who holds the grant, who finished last, packets per source),
// checks the DUT outputs every cycle, and pops/compares a beat whenever m00
// transfers. A second DUT with CNT_WIDTH=2 shares the inputs so counter
// saturation can be observed.
// -----------------------------------------------------------------------------
module tb_axis_wr_arbiter;

    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int CW = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic          l;
    } beat_t;

    logic          axis_aclk   = 1'b0;
    logic          axis_areset = 1'b1;

    logic [DW-1:0] sd [2];
    logic [SW-1:0] ss [2];
    logic          sv [2];
    logic          sl [2];
    logic          sr [2];
    logic          xr [2];

    logic [DW-1:0] md, xmd;
    logic [SW-1:0] ms, xms;
    logic          mv, ml, mid, xmv, xml, xmid;
    logic          mr;
    logic [CW-1:0] c0, c1;
    logic [1:0]    xc0, xc1;
    logic          busy, xbusy;

    // stimulus and scoreboard state
    beat_t       bq [2][$];      // packets waiting to be presented
    beat_t       eq [2][$];      // presented, not yet transferred
    logic        rq [$];         // optional explicit m00_axis_tready pattern
    int          gap_pct   = 0;
    int          ready_pct = 100;

    // reference model state
    int          owner = -1;     // source holding the grant, -1 when idle
    int          pref  = 1;      // source that finished last
    int          cnt [2] = '{0, 0};

    // transfer logs
    logic [DW-1:0] log_d   [$];
    int            log_tid [$];
    int            log_cyc [$];
    logic          log_l   [$];
    int            pkt_order [$];
    int            xfer_cnt = 0;
    int            cyc      = 0;

    int checks = 0;
    int errors = 0;

    axis_wr_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .axis_aclk       (axis_aclk),
        .axis_areset     (axis_areset),
        .s00_axis_tdata  (sd[0]),
        .s00_axis_tstrb  (ss[0]),
        .s00_axis_tvalid (sv[0]),
        .s00_axis_tlast  (sl[0]),
        .s00_axis_tready (sr[0]),
        .s01_axis_tdata  (sd[1]),
        .s01_axis_tstrb  (ss[1]),
        .s01_axis_tvalid (sv[1]),
        .s01_axis_tlast  (sl[1]),
        .s01_axis_tready (sr[1]),
        .m00_axis_tdata  (md),
        .m00_axis_tstrb  (ms),
        .m00_axis_tvalid (mv),
        .m00_axis_tlast  (ml),
        .m00_axis_tid    (mid),
        .m00_axis_tready (mr),
        .s00_pkt_count   (c0),
        .s01_pkt_count   (c1),
        .busy            (busy)
    );

    axis_wr_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_sat (
        .axis_aclk       (axis_aclk),
        .axis_areset     (axis_areset),
        .s00_axis_tdata  (sd[0]),
        .s00_axis_tstrb  (ss[0]),
        .s00_axis_tvalid (sv[0]),
        .s00_axis_tlast  (sl[0]),
        .s00_axis_tready (xr[0]),
        .s01_axis_tdata  (sd[1]),
        .s01_axis_tstrb  (ss[1]),
        .s01_axis_tvalid (sv[1]),
        .s01_axis_tlast  (sl[1]),
        .s01_axis_tready (xr[1]),
        .m00_axis_tdata  (xmd),
        .m00_axis_tstrb  (xms),
        .m00_axis_tvalid (xmv),
        .m00_axis_tlast  (xml),
        .m00_axis_tid    (xmid),
        .m00_axis_tready (mr),
        .s00_pkt_count   (xc0),
        .s01_pkt_count   (xc1),
        .busy            (xbusy)
    );

    initial forever #5 axis_aclk = ~axis_aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input bit v0, input bit v1, input int p);
        if (v0 && v1) return (p == 0) ? 1 : 0;
        if (v0)       return 0;
        if (v1)       return 1;
        return -1;
    endfunction

    function automatic int sat(input int c, input int maxv);
        return (c > maxv) ? maxv : c;
    endfunction

    // ---------------------------------------------------------------- driver
    initial begin : driver
        bit    pres [2];
        bit    hs   [2];
        beat_t b;
        for (int n = 0; n < 2; n++) begin
            sd[n] = '0; ss[n] = '0; sv[n] = 1'b0; sl[n] = 1'b0;
            pres[n] = 1'b0;
        end
        mr = 1'b0;
        forever begin
            @(negedge axis_aclk);
            for (int n = 0; n < 2; n++) hs[n] = sv[n] && sr[n];
            @(posedge axis_aclk);
            #2;
            for (int n = 0; n < 2; n++) begin
                if (hs[n]) pres[n] = 1'b0;
                if (axis_areset) begin
                    pres[n] = 1'b0;
                end else if (!pres[n] && bq[n].size() > 0 &&
                             $urandom_range(99, 0) >= gap_pct) begin
                    b = bq[n].pop_front();
                    sd[n] = b.d; ss[n] = b.s; sl[n] = b.l;
                    pres[n] = 1'b1;
                    eq[n].push_back(b);
                end
                sv[n] = pres[n];
            end
            if (rq.size() > 0) mr = rq.pop_front();
            else               mr = ($urandom_range(99, 0) < ready_pct);
        end
    end

    // --------------------------------------------------------------- monitor
    initial begin : monitor
        int    own, nxt;
        bit    xf;
        beat_t b;
        forever begin
            @(negedge axis_aclk);
            cyc++;
            own = owner;
            check("busy", busy, own != -1);
            check("s00_tready", sr[0], own == 0 && mr);
            check("s01_tready", sr[1], own == 1 && mr);
            if (own < 0) begin
                check("idle_tvalid", mv, 0);
                check("idle_tlast", ml, 0);
                check("idle_tid", mid, 0);
                check("idle_tdata", md, 0);
                check("idle_tstrb", ms, 0);
            end else begin
                check("tvalid", mv, sv[own]);
                check("tid", mid, own);
                if (sv[own]) begin
                    check("beat_pending", eq[own].size() != 0, 1);
                    if (eq[own].size() != 0) begin
                        check("tdata", md, eq[own][0].d);
                        check("tstrb", ms, eq[own][0].s);
                        check("tlast", ml, eq[own][0].l);
                    end
                end
            end
            check("s00_pkt_count", c0, sat(cnt[0], 65535));
            check("s01_pkt_count", c1, sat(cnt[1], 65535));
            check("sat_s00_pkt_count", xc0, sat(cnt[0], 3));
            check("sat_s01_pkt_count", xc1, sat(cnt[1], 3));

            nxt = own;
            xf  = (own >= 0) && sv[own] && mr;
            if (own < 0) begin
                nxt = pick(sv[0], sv[1], pref);
            end else if (xf && eq[own].size() != 0) begin
                b = eq[own].pop_front();
                xfer_cnt++;
                log_d.push_back(b.d);
                log_tid.push_back(own);
                log_cyc.push_back(cyc);
                log_l.push_back(b.l);
                if (b.l) begin
                    cnt[own]++;
                    pref = own;
                    pkt_order.push_back(own);
                    nxt = sv[1 - own] ? 1 - own : -1;
                end
            end
            if (axis_areset) begin
                nxt  = -1;
                pref = 1;
                cnt  = '{0, 0};
                eq[0].delete();
                eq[1].delete();
            end
            owner = nxt;
        end
    end

    // ------------------------------------------------------------ main tasks
    task automatic cycles(input int k);
        repeat (k) @(posedge axis_aclk);
        #1;
    endtask

    task automatic do_reset();
        axis_areset = 1'b1;
        bq[0].delete();
        bq[1].delete();
        cycles(2);
        axis_areset = 1'b0;
    endtask

    task automatic clear_logs();
        log_d.delete(); log_tid.delete(); log_cyc.delete(); log_l.delete();
        pkt_order.delete();
    endtask

    task automatic push_pkt(input int n, input int len, input logic [DW-1:0] base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = base * DW'(i + 1);
            b.s = '1;
            b.l = (i == len - 1);
            bq[n].push_back(b);
        end
    endtask

    task automatic push_rand_pkt(input int n, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = $urandom;
            b.s = SW'($urandom_range(15, 0));
            b.l = (i == len - 1);
            bq[n].push_back(b);
        end
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while ((bq[0].size() != 0 || bq[1].size() != 0 ||
                eq[0].size() != 0 || eq[1].size() != 0) && t < budget) begin
            cycles(1);
            t++;
        end
        check("drain_in_time", t < budget, 1);
        cycles(3);
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int t = 0;
        while (xfer_cnt < target && t < budget) begin
            cycles(1);
            t++;
        end
        check("xfer_in_time", t < budget, 1);
    endtask

    // ------------------------------------------------------------- main flow
    initial begin : main
        int n0, n1, src, base_xfer;
        logic [DW-1:0] bp_data [4];

        // reset held two cycles, then idle with no tvalid
        cycles(2);
        axis_areset = 1'b0;
        cycles(10);
        check("idle_busy", busy, 0);
        check("idle_count0", c0, 0);
        check("idle_count1", c1, 0);

        // single source, 4-beat packet 0x11..0x44
        do_reset();
        clear_logs();
        push_pkt(0, 4, 32'h11);
        wait_drain(100);
        check("single_beats", log_d.size(), 4);
        if (log_d.size() == 4) begin
            check("single_d0", log_d[0], 32'h11);
            check("single_d1", log_d[1], 32'h22);
            check("single_d2", log_d[2], 32'h33);
            check("single_d3", log_d[3], 32'h44);
            check("single_last_early", log_l[2], 0);
            check("single_last", log_l[3], 1);
            check("single_tid", log_tid[3], 0);
        end
        check("single_count0", c0, 1);
        check("single_busy_after", busy, 0);

        // tie: both sources present two 2-beat packets continuously
        do_reset();
        clear_logs();
        push_pkt(0, 2, 32'h100);
        push_pkt(1, 2, 32'h200);
        push_pkt(0, 2, 32'h300);
        push_pkt(1, 2, 32'h400);
        wait_drain(100);
        check("tie_pkts", pkt_order.size(), 4);
        if (pkt_order.size() == 4) begin
            check("tie_order0", pkt_order[0], 0);
            check("tie_order1", pkt_order[1], 1);
            check("tie_order2", pkt_order[2], 0);
            check("tie_order3", pkt_order[3], 1);
        end
        if (log_cyc.size() == 8)
            check("tie_no_bubble", log_cyc[7] - log_cyc[0], 7);
        else
            check("tie_beats", log_cyc.size(), 8);
        check("tie_count0", c0, 2);
        check("tie_count1", c1, 2);

        // backpressure during an s01 packet
        clear_logs();
        bp_data = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
        foreach (bp_data[i]) begin
            beat_t b;
            b.d = bp_data[i]; b.s = 4'h5; b.l = (i == 3);
            bq[1].push_back(b);
        end
        rq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        wait_drain(100);
        check("bp_beats", log_d.size(), 4);
        if (log_d.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("bp_data", log_d[i], bp_data[i]);
                check("bp_tid", log_tid[i], 1);
            end
        end
        check("bp_count1", c1, 3);

        // grant atomicity: s01 requests after s00 beat 1
        clear_logs();
        base_xfer = xfer_cnt;
        push_pkt(0, 3, 32'h5000);
        wait_xfers(base_xfer + 1, 50);
        push_pkt(1, 2, 32'h6000);
        wait_drain(100);
        check("atom_beats", log_tid.size(), 5);
        if (log_tid.size() == 5) begin
            check("atom_tid1", log_tid[1], 0);
            check("atom_tid2", log_tid[2], 0);
            check("atom_last0", log_l[2], 1);
            check("atom_tid3", log_tid[3], 1);
            check("atom_handoff", log_cyc[3] - log_cyc[2], 1);
        end

        // reset after beat 2 of a 5-beat packet
        clear_logs();
        base_xfer = xfer_cnt;
        push_pkt(0, 5, 32'h7000);
        wait_xfers(base_xfer + 2, 50);
        axis_areset = 1'b1;
        bq[0].delete();
        cycles(1);
        axis_areset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_count0", c0, 0);
        check("rst_count1", c1, 0);
        check("rst_s00_tready", sr[0], 0);
        check("rst_beats", log_d.size(), 2);
        foreach (log_l[i]) check("rst_no_tlast", log_l[i], 0);
        cycles(3);

        // saturation on the CNT_WIDTH=2 instance
        for (int i = 0; i < 5; i++) push_pkt(0, 1 + (i % 3), 32'h8000 + i);
        wait_drain(200);
        check("sat_count", xc0, 3);
        check("full_count", c0, 5);

        // randomized traffic with gaps and backpressure
        gap_pct = 30;
        ready_pct = 70;
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 40; i++) begin
            src = $urandom_range(1, 0);
            push_rand_pkt(src, $urandom_range(5, 1));
            if (src == 0) n0++; else n1++;
        end
        wait_drain(5000);
        check("rand_count0", c0, 5 + n0);
        check("rand_count1", c1, n1);
        check("rand_busy_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
